// File: rtl/segre_store_buffer_n.sv
// Word-granular coalescing store buffer between the LSU and the L1 data cache.
// Stores merge by byte enable into a live entry for the same word, else allocate FIFO-order.

package segre_store_buffer_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

module segre_store_buffer_n
  import segre_store_buffer_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             store_valid_i,
  output logic                             store_ready_o,
  input  logic [ADDR_SIZE-1:0]             store_addr_i,
  input  logic [WORD_SIZE-1:0]             store_data_i,
  input  memop_data_type_e                 store_type_i,
  input  logic                             load_valid_i,
  input  logic [ADDR_SIZE-1:0]             load_addr_i,
  input  memop_data_type_e                 load_type_i,
  output logic                             load_hit_o,
  output logic                             load_partial_o,
  output logic                             load_miss_o,
  output logic [WORD_SIZE-1:0]             load_data_o,
  output logic                             flush_valid_o,
  input  logic                             flush_ready_i,
  output logic [ADDR_SIZE-1:0]             flush_addr_o,
  output logic [WORD_SIZE-1:0]             flush_data_o,
  output logic [3:0]                       flush_be_o,
  input  logic                             drain_i,
  output logic                             empty_o,
  output logic                             full_o,
  output logic [$clog2(NUM_ELEMS+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(NUM_ELEMS);
  localparam int unsigned CntW = $clog2(NUM_ELEMS + 1);
  localparam int unsigned WaW  = ADDR_SIZE - 2;

  logic [NUM_ELEMS-1:0] valid_q;
  logic [WaW-1:0]       waddr_q [NUM_ELEMS];
  logic [WORD_SIZE-1:0] data_q  [NUM_ELEMS];
  logic [3:0]           be_q    [NUM_ELEMS];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q;

  function automatic logic [1:0] lane_off(memop_data_type_e t, logic [1:0] off);
    unique case (t)
      BYTE:    lane_off = off;
      HALF:    lane_off = {off[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(memop_data_type_e t, logic [1:0] off);
    unique case (t)
      BYTE:    byte_mask = 4'b0001 << off;
      HALF:    byte_mask = 4'b0011 << {off[1], 1'b0};
      default: byte_mask = 4'hF;
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] lane_expand(logic [3:0] m);
    for (int b = 0; b < 4; b++) lane_expand[8*b +: 8] = {8{m[b]}};
  endfunction

  // Store-side lookup
  logic [3:0]           st_mask;
  logic [WORD_SIZE-1:0] st_lanes, st_lmask;
  logic [NUM_ELEMS-1:0] st_match;
  logic                 st_hit;
  logic [PtrW-1:0]      st_idx;

  always_comb begin
    st_mask  = byte_mask(store_type_i, store_addr_i[1:0]);
    st_lmask = lane_expand(st_mask);
    st_lanes = store_data_i << {lane_off(store_type_i, store_addr_i[1:0]), 3'b000};
    st_idx   = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      st_match[i] = valid_q[i] && (waddr_q[i] == store_addr_i[ADDR_SIZE-1:2]);
      if (st_match[i]) st_idx = i[PtrW-1:0];
    end
    st_hit = |st_match;
  end

  // Load-side lookup: pre-update state only
  logic [3:0]           ld_sel, ld_be;
  logic [WORD_SIZE-1:0] ld_data;
  logic                 ld_match, ld_all;

  always_comb begin
    ld_sel   = byte_mask(load_type_i, load_addr_i[1:0]);
    ld_be    = '0;
    ld_data  = '0;
    ld_match = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (valid_q[i] && (waddr_q[i] == load_addr_i[ADDR_SIZE-1:2])) begin
        ld_match = 1'b1;
        ld_be    = ld_be | be_q[i];
        ld_data  = ld_data | data_q[i];
      end
    end
    ld_all         = (ld_be & ld_sel) == ld_sel;
    load_hit_o     = load_valid_i && ld_match && ld_all;
    load_partial_o = load_valid_i && ld_match && !ld_all;
    load_miss_o    = load_valid_i && !ld_match;
    load_data_o    = '0;
    if (load_hit_o) begin
      load_data_o = (ld_data & lane_expand(ld_sel))
                    >> {lane_off(load_type_i, load_addr_i[1:0]), 3'b000};
    end
  end

  logic flush_fire, store_fire, alloc;

  always_comb begin
    empty_o       = rst_i || (count_q == '0);
    full_o        = !rst_i && (count_q == CntW'(NUM_ELEMS));
    count_o       = count_q;
    flush_valid_o = !empty_o;
    flush_addr_o  = {waddr_q[tail_q], 2'b00};
    flush_data_o  = data_q[tail_q];
    flush_be_o    = be_q[tail_q];
    flush_fire    = flush_valid_o && flush_ready_i;
    // Coalescing into the entry leaving this cycle would lose the bytes; stall instead.
    store_ready_o = !rst_i && !drain_i &&
                    (st_hit ? !(st_match[tail_q] && flush_fire) : !full_o);
    store_fire    = store_valid_i && store_ready_o;
    alloc         = store_fire && !st_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        valid_q[i] <= 1'b0;
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (store_fire && st_hit) begin
        data_q[st_idx] <= (data_q[st_idx] & ~st_lmask) | (st_lanes & st_lmask);
        be_q[st_idx]   <= be_q[st_idx] | st_mask;
      end
      if (alloc) begin
        valid_q[head_q] <= 1'b1;
        waddr_q[head_q] <= store_addr_i[ADDR_SIZE-1:2];
        data_q[head_q]  <= st_lanes & st_lmask;
        be_q[head_q]    <= st_mask;
        head_q          <= head_q + 1'b1;
      end
      if (flush_fire) begin
        valid_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      unique case ({alloc, flush_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_store_buffer_n.sv
// Directed bench for segre_store_buffer_n: a queue-of-words model checked every cycle
// plus literal expectations at the key points.

module tb_segre_store_buffer_n;
  import segre_store_buffer_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst, store_valid, store_ready, load_valid;
  logic [31:0]      store_addr, store_data, load_addr;
  memop_data_type_e store_type, load_type;
  logic             load_hit, load_partial, load_miss;
  logic [31:0]      load_data;
  logic             flush_valid, flush_ready, drain, empty, full;
  logic [31:0]      flush_addr, flush_data;
  logic [3:0]       flush_be;
  logic [2:0]       count;

  always #5 clk = ~clk;

  segre_store_buffer_n #(.NUM_ELEMS(N), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .store_valid_i(store_valid), .store_ready_o(store_ready), .store_addr_i(store_addr),
    .store_data_i(store_data), .store_type_i(store_type),
    .load_valid_i(load_valid), .load_addr_i(load_addr), .load_type_i(load_type),
    .load_hit_o(load_hit), .load_partial_o(load_partial), .load_miss_o(load_miss),
    .load_data_o(load_data),
    .flush_valid_o(flush_valid), .flush_ready_i(flush_ready), .flush_addr_o(flush_addr),
    .flush_data_o(flush_data), .flush_be_o(flush_be),
    .drain_i(drain), .empty_o(empty), .full_o(full), .count_o(count)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of live words, oldest first.
  typedef struct packed {
    logic [29:0]      w;
    logic [3:0][7:0]  b;
    logic [3:0]       be;
  } ent_t;
  ent_t q[$];

  function automatic int find(input logic [31:0] a);
    for (int i = 0; i < q.size(); i++) if (q[i].w == a[31:2]) return i;
    return -1;
  endfunction

  function automatic int nbytes(input memop_data_type_e t);
    return (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
  endfunction

  function automatic int base(input memop_data_type_e t, input logic [31:0] a);
    return (t == BYTE) ? int'(a[1:0]) : (t == HALF) ? 2 * int'(a[1]) : 0;
  endfunction

  function automatic logic [3:0] sel_of(input memop_data_type_e t, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    for (int j = 0; j < nbytes(t); j++) m[base(t, a) + j] = 1'b1;
    return m;
  endfunction

  logic        exp_sfire = 1'b0, exp_ffire = 1'b0;
  logic        ev, er, eh, ep, em;
  logic [31:0] ed;
  logic [3:0]  sel;
  int          si, li;

  always @(negedge clk) begin
    ev = !rst && q.size() != 0;
    chk("empty", 32'(empty), 32'(!ev));
    chk("full", 32'(full), 32'(!rst && q.size() == N));
    chk("count", 32'(count), 32'(q.size()));
    chk("flush_valid", 32'(flush_valid), 32'(ev));
    if (ev) begin
      chk("flush_addr", flush_addr, {q[0].w, 2'b00});
      chk("flush_data", flush_data, q[0].b);
      chk("flush_be", 32'(flush_be), 32'(q[0].be));
    end
    si = find(store_addr);
    er = !rst && !drain && ((si >= 0) ? !(si == 0 && ev && flush_ready) : q.size() < N);
    chk("store_ready", 32'(store_ready), 32'(er));
    exp_sfire = store_valid && er;
    exp_ffire = ev && flush_ready;
    {eh, ep, em} = 3'b000;
    ed = 32'h0;
    if (load_valid) begin
      li  = find(load_addr);
      sel = sel_of(load_type, load_addr);
      if (li < 0) em = 1'b1;
      else if ((q[li].be & sel) == sel) begin
        eh = 1'b1;
        for (int j = 0; j < nbytes(load_type); j++)
          ed[8*j +: 8] = q[li].b[base(load_type, load_addr) + j];
      end else ep = 1'b1;
    end
    chk("load_hit", 32'(load_hit), 32'(eh));
    chk("load_partial", 32'(load_partial), 32'(ep));
    chk("load_miss", 32'(load_miss), 32'(em));
    chk("load_data", load_data, ed);
  end

  always @(posedge clk) begin
    ent_t e;
    int   k;
    if (rst) q.delete();
    else begin
      if (exp_sfire) begin
        k = find(store_addr);
        if (k >= 0) e = q[k];
        else e = '{w: store_addr[31:2], b: '0, be: 4'h0};
        for (int j = 0; j < nbytes(store_type); j++)
          e.b[base(store_type, store_addr) + j] = store_data[8*j +: 8];
        e.be = e.be | sel_of(store_type, store_addr);
        if (k >= 0) q[k] = e;
        else q.push_back(e);
      end
      if (exp_ffire) void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_type  = t;
    step();
    store_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; store_valid = 1'b0; store_addr = '0; store_data = '0; store_type = WORD;
    load_valid = 1'b0; load_addr = '0; load_type = WORD; flush_ready = 1'b0; drain = 1'b0;
    step(); step(); #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(store_ready), 32'd0);
    rst = 1'b0;
    step();

    // Single word store appears at the flush port.
    st(32'h100, 32'hDEADBEEF, WORD); #1;
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_fvalid", 32'(flush_valid), 32'd1);
    chk("t1_faddr", flush_addr, 32'h100);
    chk("t1_fbe", 32'(flush_be), 32'hF);
    chk("t1_fdata", flush_data, 32'hDEADBEEF);
    flush_ready = 1'b1; step(); flush_ready = 1'b0; #1;
    chk("t1_empty", 32'(empty), 32'd1);

    // Coalescing and load forwarding.
    st(32'h201, 32'h000000AA, BYTE);
    st(32'h202, 32'h00001234, HALF); #1;
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_fbe", 32'(flush_be), 32'hE);
    chk("t2_fdata", flush_data, 32'h1234AA00);
    load_valid = 1'b1; load_addr = 32'h201; load_type = BYTE; #1;
    chk("t2_ld_hit", 32'(load_hit), 32'd1);
    chk("t2_ld_data", load_data, 32'h000000AA);
    load_addr = 32'h200; load_type = WORD; #1;
    chk("t2_ld_partial", 32'(load_partial), 32'd1);
    chk("t2_ld_data0", load_data, 32'h0);
    load_valid = 1'b0;

    // Fill, reject a new word, coalesce into an existing one.
    st(32'h300, 32'h33333333, WORD);
    st(32'h400, 32'h44444444, WORD);
    st(32'h500, 32'h55555555, WORD); #1;
    chk("t3_full", 32'(full), 32'd1);
    store_valid = 1'b1; store_addr = 32'h600; store_data = 32'h66666666; store_type = WORD; #1;
    chk("t3_ready_full", 32'(store_ready), 32'd0);
    step();
    store_addr = 32'h303; store_data = 32'h00000055; store_type = BYTE; #1;
    chk("t3_ready_merge", 32'(store_ready), 32'd1);
    step(); store_valid = 1'b0; #1;
    chk("t3_count", 32'(count), 32'd4);

    // Pop while full stalls a new-word store for one cycle.
    store_valid = 1'b1; store_addr = 32'h600; store_data = 32'h66666666; store_type = WORD;
    flush_ready = 1'b1; #1;
    chk("t4_ready_pop", 32'(store_ready), 32'd0);
    step(); flush_ready = 1'b0; #1;
    chk("t4_ready_next", 32'(store_ready), 32'd1);
    step(); store_valid = 1'b0; #1;
    chk("t4_count", 32'(count), 32'd4);

    // Wrap the pointers with alloc/pop pairs.
    flush_ready = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
      store_valid = 1'b1; store_addr = 32'h1000 + 32'(16 * k); store_data = 32'(k);
      store_type = WORD; #1;
      chk("wrap_faddr", flush_addr,
          (k < 3) ? 32'h400 + 32'(256 * k) : 32'h1000 + 32'(16 * (k - 3)));
      chk("wrap_ready", 32'(store_ready), 32'd1);
      step();
    end
    store_valid = 1'b0; flush_ready = 1'b0;

    // Store to the tail being popped stalls, then reallocates with only its own byte.
    store_valid = 1'b1; store_addr = 32'h1050; store_data = 32'h77; store_type = BYTE;
    flush_ready = 1'b1; #1;
    chk("t5_ready_tail", 32'(store_ready), 32'd0);
    step(); flush_ready = 1'b0; #1;
    chk("t5_ready_next", 32'(store_ready), 32'd1);
    step(); store_valid = 1'b0;
    load_valid = 1'b1; load_addr = 32'h1051; load_type = BYTE; #1;
    chk("t5_ld_partial", 32'(load_partial), 32'd1);
    load_addr = 32'h1050; #1;
    chk("t5_ld_data", load_data, 32'h77);
    load_valid = 1'b0;

    // Drain empties the buffer while blocking stores.
    drain = 1'b1; flush_ready = 1'b1;
    store_valid = 1'b1; store_addr = 32'h2000; store_data = 32'h2; store_type = WORD;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t6_ready_drain", 32'(store_ready), 32'd0);
      step();
    end
    #1 chk("t6_empty", 32'(empty), 32'd1);
    store_valid = 1'b0; drain = 1'b0; flush_ready = 1'b0;

    // Reset mid-drain discards the in-flight handshake.
    st(32'h3000, 32'hA, WORD);
    st(32'h3004, 32'hB, WORD);
    st(32'h3008, 32'hC, WORD);
    drain = 1'b1; flush_ready = 1'b1;
    step();
    rst = 1'b1; #1;
    chk("t6_rst_fvalid", 32'(flush_valid), 32'd0);
    step(); rst = 1'b0; #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_fvalid2", 32'(flush_valid), 32'd0);
    drain = 1'b0; flush_ready = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/segre_store_buffer_n.md
Name: segre_store_buffer_n

Overview:
Parametrised, word-granular, coalescing store buffer placed between the LSU and the L1 data cache. Stores are accepted with a valid/ready handshake and merged by byte-enable into an existing entry for the same word, or allocated in FIFO order. Entries drain to the cache oldest-first over a valid/ready flush port. Loads get same-cycle forwarding with full, partial or miss classification; a drain request supports fences.

Parameters:
NUM_ELEMS, 4, entry count; power of two, >=2
ADDR_SIZE, 32, address width
WORD_SIZE, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
store_valid_i  in  1  store request
store_ready_o  out  1  store accepted when valid&ready
store_addr_i  in  ADDR_SIZE  store byte address
store_data_i  in  WORD_SIZE  store data, right-justified
store_type_i  in  memop_data_type_e  BYTE/HALF/WORD
load_valid_i  in  1  load lookup request
load_addr_i  in  ADDR_SIZE  load byte address
load_type_i  in  memop_data_type_e  load size
load_hit_o  out  1  all requested bytes present in the buffer
load_partial_o  out  1  word matched but some requested bytes absent
load_miss_o  out  1  no entry matches the word
load_data_o  out  WORD_SIZE  forwarded data, right-justified, upper bits zero
flush_valid_o  out  1  oldest entry presented to the cache
flush_ready_i  in  1  cache takes the entry this cycle
flush_addr_o  out  ADDR_SIZE  word address, bits [1:0]=0
flush_data_o  out  WORD_SIZE  lane-aligned data
flush_be_o  out  4  byte enables
drain_i  in  1  fence: block new stores until empty
empty_o  out  1  no valid entries
full_o  out  1  all entries valid
count_o  out  $clog2(NUM_ELEMS+1)  valid entry count

Behaviour:
- Entry fields: valid, word address (addr[ADDR_SIZE-1:2]), 4x8 data, 4-bit be. Invariant: at most one valid entry per word address.
- Byte mask: BYTE = 1<<addr[1:0]; HALF = 2'b11<<{addr[1],1'b0}; WORD = 4'hF. Ignore addr[0] for HALF and addr[1:0] for WORD; no misalignment trap. Data lanes use the same shift.
- Head, tail and count are registered; head and tail wrap modulo NUM_ELEMS.
- Store match: compare the word address against all valid entries (one-hot).
- Coalesce on match: OR the mask into be and write masked lanes; younger bytes overwrite older ones. No count change.
- Allocate on no match: write entry at head (be = mask, unmasked lanes zero), set valid, head+1, count+1.
- store_ready_o = !rst_i & !drain_i & (match ? !(match_is_tail & flush fire) : !full_o). A store matching the tail entry popped in the same cycle stalls one cycle.
- full_o uses the pre-pop count: no allocate-on-pop when full.
- Flush: flush_valid_o = !empty_o; outputs come from tail and are combinational from registers. On valid&ready, clear tail.valid, tail+1, count-1. Outputs stay stable while valid && !ready.
- Simultaneous allocate and pop: count unchanged, both pointers advance.
- Load lookup is combinational on the pre-update state; a same-cycle store is not visible. With sel = load mask:
  - hit when match and (be & sel) == sel;
  - partial when match and (be & sel) != sel;
  - miss when no match.
  - Exactly one of hit/partial/miss is high when load_valid_i=1; all are 0 otherwise.
  - load_data_o is selected lanes shifted down on hit, otherwise 0.
- drain_i is level-sensitive. Flushing continues while it is high; the LSU waits for empty_o.
- Reset (any cycle, including mid-flush):
  - all entries invalid, be=0, data=0; head=tail=count=0;
  - empty_o=1, full_o=0, flush_valid_o=0, store_ready_o=0 while rst_i is high;
  - an in-flight flush handshake in the reset cycle is discarded.
- empty_o = (count==0); full_o = (count==NUM_ELEMS).

Test Plan:
- Reset, then store WORD 0x100=0xDEADBEEF -> next cycle count_o=1, flush_valid_o=1, flush_addr_o=0x100, flush_be_o=4'hF, flush_data_o=0xDEADBEEF.
- With flush_ready_i=0: store BYTE 0x201=0xAA, then HALF 0x202=0x1234 -> count_o=1, be=4'b1110, data=0x1234AA00. Load BYTE 0x201 -> hit, load_data_o=0x000000AA. Load WORD 0x200 -> partial, load_data_o=0.
- Fill 4 distinct words -> full_o=1. A 5th new-word store -> store_ready_o=0. A store to an existing word -> accepted, coalesced, count_o stays 4.
- Full buffer with flush_ready_i=1 and a new-word store in the same cycle -> pop accepted, store stalled; next cycle the store is accepted and count_o returns to 4. Wrap: 8 alloc/pop pairs keep FIFO order of flush_addr_o.
- Store matching the tail while flush_ready_i=1 -> store_ready_o=0 that cycle. Next cycle the store allocates a new entry: be=mask only, old bytes absent.
- drain_i=1 with 3 entries and flush_ready_i=1 -> store_ready_o=0 throughout, empty_o=1 after 3 cycles. Assert rst_i mid-drain -> next cycle count_o=0, flush_valid_o=0.
